rrg_cmd_sequencer: RTL and testbench
====================================

RRG_CMD_SEQUENCER -- requirements
Module: rrg_cmd_sequencer

Interface
REQ-001 SHALL have parameter NR_DATASETS, default 2: number of ramp-generator datasets; valid indices are 0..NR_DATASETS-1.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2 (legal range 1..15): clocks each command is held on reg_control.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-004 SHALL have port nReset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: a parameter-set load request is present.
REQ-006 SHALL have port req_ready, output, 1: the sequencer accepts a request this cycle.
REQ-007 SHALL have port req_dataset, input, 8: target dataset index.
REQ-008 SHALL have ports req_yset, req_rset, req_riset, req_roset, input, 64 each: set value, ramp rate, round-in rate and round-out rate.
REQ-009 SHALL have port req_activate, input, 1: after the update, switch the active dataset to req_dataset.
REQ-010 SHALL have port reg_control, output, 16: [15:8] dataset index, [7:0] command code (0 IDLE, 1 WRITE_YSET, 2 WRITE_RSET, 3 WRITE_RISET, 4 WRITE_ROSET, 5 UPDATE, 6 SW_DATASET).
REQ-011 SHALL have ports reg_0, reg_1, reg_2, reg_3, output, 16 each: value word, with reg_3 = bits 63:48 and reg_0 = bits 15:0.
REQ-012 SHALL have port busy, output, 1: high while a sequence is in progress.
REQ-013 SHALL have port err_dataset, output, 1: one-cycle pulse when a request is rejected for an out-of-range dataset.

Function
REQ-014 SHALL implement these states: IDLE, WR_Y, WR_R, WR_RI, WR_RO, UPD, SW, GAP. All outputs SHALL be registered.
REQ-015 SHALL drive req_ready = 1 only in IDLE when reset is not asserted. A handshake occurs at an edge where req_valid and req_ready are both 1; all request fields and req_activate SHALL be captured at that edge.
REQ-016 SHALL, for an accepted request with req_dataset >= NR_DATASETS, pulse err_dataset in the next cycle, issue no command, and remain in IDLE with req_ready = 1.
REQ-017 SHALL, for a valid request, drive WRITE_YSET on reg_control in the first cycle after acceptance; busy = 1 and req_ready = 0 from that cycle.
REQ-018 SHALL hold each command (code, dataset and value) for exactly HOLD_CYCLES cycles, then drive one GAP cycle with code 0, dataset unchanged and reg_0..3 = 0.
REQ-019 SHALL issue commands in the order WR_Y, WR_R, WR_RI, WR_RO, UPD, then SW only if the captured req_activate = 1.
REQ-020 SHALL drive the value words with the captured field in WR_* states, and with 0 in UPD and SW.
REQ-021 SHALL return to IDLE after the last GAP: req_ready = 1, busy = 0, reg_control = 0. Sequence length SHALL be 5*(HOLD_CYCLES+1) cycles, or 6*(HOLD_CYCLES+1) with activate.
REQ-022 SHALL ignore req_valid and all request inputs while busy; input changes SHALL NOT alter an issued sequence.
REQ-023 SHALL NOT issue an UPD command unless all four WR_* commands of the same sequence have completed.
REQ-024 SHALL allow back-to-back requests: with req_valid held high, the next acceptance occurs in the first IDLE cycle, giving one idle reg_control cycle between sequences.

Reset
REQ-025 SHALL, when nReset = 0 at an edge, set state IDLE; reg_control, reg_0..3, busy and err_dataset to 0; req_ready to 0 during reset and to 1 in the first cycle after release.
REQ-026 SHALL abandon any in-flight sequence on reset without completing it, and SHALL issue no UPD or SW after reset release until a new request is accepted.

Configuration
REQ-027 SHALL, when macro RRG_SEQ_ERRCNT_EN is defined, add output err_count, 8 bits, reset 0, incremented on each err_dataset pulse and saturating at 255. Without the macro the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (HOLD_CYCLES = 2)
REQ-028 Accept dataset=1, yset=0x0000_1234_5678_9ABC, activate=0 -> reg_control 0x0101 x2, 0x0100 x1, then 0x0102/0x0103/0x0104/0x0105 similarly; reg_3..0 = 0000/1234/5678/9ABC during WR_Y; ready again after 15 cycles.
REQ-029 Same request with activate=1 -> additionally 0x0106 x2 plus gap; busy high for exactly 18 cycles.
REQ-030 dataset=5 with NR_DATASETS=2 -> err_dataset pulses 1 cycle, reg_control stays 0, ready stays 1; with RRG_SEQ_ERRCNT_EN, err_count = 1.
REQ-031 nReset low during WR_RO -> next cycle all outputs 0; after release no 0x__05 appears until a new handshake.
REQ-032 req_valid held high with 3 queued requests and inputs changed mid-sequence -> three complete sequences, each carrying only its captured values, separated by one idle cycle.
REQ-033 With RRG_SEQ_ERRCNT_EN, 300 invalid requests -> err_count saturates at 255.

Source files
------------

// File: rtl/rrg_cmd_sequencer.sv
// Ramp-generator command sequencer.
// Turns one parameter-set load request into a fixed series of register commands:
// WRITE_YSET, WRITE_RSET, WRITE_RISET, WRITE_ROSET, UPDATE and an optional SW_DATASET.
// Each command is held for HOLD_CYCLES clocks and followed by one gap cycle.
// Optional feature: define RRG_SEQ_ERRCNT_EN to add a saturating err_count output.
module rrg_cmd_sequencer #(
  parameter int unsigned NR_DATASETS = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dataset,
  input  logic [63:0] req_yset,
  input  logic [63:0] req_rset,
  input  logic [63:0] req_riset,
  input  logic [63:0] req_roset,
  input  logic        req_activate,
  output logic [15:0] reg_control,
  output logic [15:0] reg_0,
  output logic [15:0] reg_1,
  output logic [15:0] reg_2,
  output logic [15:0] reg_3,
`ifdef RRG_SEQ_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        busy,
  output logic        err_dataset
);

  typedef enum logic [2:0] {
    StIdle, StWrY, StWrR, StWrRi, StWrRo, StUpd, StSw, StGap
  } state_t;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_t      state_q;
  state_t      last_q;   // command that precedes the current gap
  state_t      nxt_cmd;
  logic [3:0]  cnt_q;
  logic [7:0]  ds_q;
  logic        act_q;
  logic [63:0] rset_q;
  logic [63:0] riset_q;
  logic [63:0] roset_q;
  logic [63:0] val_q;
  logic [7:0]  nxt_code;
  logic [63:0] nxt_val;
  logic        ds_ok;
  logic        accept;

  assign ds_ok  = ({24'd0, req_dataset} < NR_DATASETS);
  assign accept = (state_q == StIdle) && req_valid && req_ready;

  assign reg_0 = val_q[15:0];
  assign reg_1 = val_q[31:16];
  assign reg_2 = val_q[47:32];
  assign reg_3 = val_q[63:48];

  // Command that follows the gap, with its code and value word.
  always_comb begin
    nxt_cmd  = StIdle;
    nxt_code = 8'd0;
    nxt_val  = 64'd0;
    case (last_q)
      StWrY: begin
        nxt_cmd  = StWrR;
        nxt_code = 8'd2;
        nxt_val  = rset_q;
      end
      StWrR: begin
        nxt_cmd  = StWrRi;
        nxt_code = 8'd3;
        nxt_val  = riset_q;
      end
      StWrRi: begin
        nxt_cmd  = StWrRo;
        nxt_code = 8'd4;
        nxt_val  = roset_q;
      end
      StWrRo: begin
        nxt_cmd  = StUpd;
        nxt_code = 8'd5;
      end
      StUpd: begin
        if (act_q) begin
          nxt_cmd  = StSw;
          nxt_code = 8'd6;
        end
      end
      default: nxt_cmd = StIdle;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= StIdle;
      last_q      <= StIdle;
      cnt_q       <= 4'd0;
      ds_q        <= 8'd0;
      act_q       <= 1'b0;
      rset_q      <= 64'd0;
      riset_q     <= 64'd0;
      roset_q     <= 64'd0;
      val_q       <= 64'd0;
      reg_control <= 16'd0;
      busy        <= 1'b0;
      err_dataset <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      err_dataset <= 1'b0;
      case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (ds_ok) begin
              state_q     <= StWrY;
              last_q      <= StWrY;
              cnt_q       <= 4'd0;
              ds_q        <= req_dataset;
              act_q       <= req_activate;
              rset_q      <= req_rset;
              riset_q     <= req_riset;
              roset_q     <= req_roset;
              val_q       <= req_yset;
              reg_control <= {req_dataset, 8'd1};
              busy        <= 1'b1;
              req_ready   <= 1'b0;
            end else begin
              err_dataset <= 1'b1;
            end
          end
        end
        StGap: begin
          cnt_q <= 4'd0;
          if (nxt_cmd == StIdle) begin
            state_q     <= StIdle;
            last_q      <= StIdle;
            reg_control <= 16'd0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
          end else begin
            state_q     <= nxt_cmd;
            last_q      <= nxt_cmd;
            reg_control <= {ds_q, nxt_code};
            val_q       <= nxt_val;
          end
        end
        default: begin
          // Command states: hold, then drop to a gap with the dataset kept.
          if (cnt_q == HoldLast) begin
            state_q     <= StGap;
            reg_control <= {ds_q, 8'd0};
            val_q       <= 64'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef RRG_SEQ_ERRCNT_EN
  // Saturating count of rejected requests, stepped with each err_dataset pulse.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      err_count <= 8'd0;
    end else if (accept && !ds_ok && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rrg_cmd_sequencer.sv
// Self-checking bench for rrg_cmd_sequencer (HOLD_CYCLES = 2, NR_DATASETS = 2).
// Expected per-cycle outputs are pushed to a scoreboard queue when a request is
// driven and popped at each falling edge as the DUT produces them.
module tb_rrg_cmd_sequencer;

  localparam int unsigned Hold = 2;
  localparam int unsigned NrDs = 2;

  typedef struct packed {
    logic [15:0] ctl;
    logic [63:0] val;
    logic        busy;
    logic        ready;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_dataset = 8'd0;
  logic [63:0] req_yset = 64'd0;
  logic [63:0] req_rset = 64'd0;
  logic [63:0] req_riset = 64'd0;
  logic [63:0] req_roset = 64'd0;
  logic        req_activate = 1'b0;
  logic [15:0] reg_control, reg_0, reg_1, reg_2, reg_3;
  logic        busy, err_dataset;
`ifdef RRG_SEQ_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_errs = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rrg_cmd_sequencer #(.NR_DATASETS(NrDs), .HOLD_CYCLES(Hold)) dut (
    .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dataset(req_dataset), .req_yset(req_yset), .req_rset(req_rset),
    .req_riset(req_riset), .req_roset(req_roset), .req_activate(req_activate),
    .reg_control(reg_control), .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
`ifdef RRG_SEQ_ERRCNT_EN
    .err_count(err_count),
`endif
    .busy(busy), .err_dataset(err_dataset)
  );

  function automatic exp_t observed();
    return {reg_control, reg_3, reg_2, reg_1, reg_0, busy, req_ready, err_dataset};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: one expected entry per cycle for a whole sequence plus the idle after it.
  function automatic void push_seq(input logic [7:0] ds, input logic [63:0] y,
                                   input logic [63:0] r, input logic [63:0] ri,
                                   input logic [63:0] ro, input logic act);
    logic [63:0] f[4];
    int ncmd;
    f[0] = y; f[1] = r; f[2] = ri; f[3] = ro;
    ncmd = act ? 6 : 5;
    for (int k = 1; k <= ncmd; k++) begin
      for (int h = 0; h < int'(Hold); h++)
        sb.push_back('{ctl: {ds, 8'(k)}, val: (k <= 4) ? f[k-1] : 64'd0,
                       busy: 1'b1, ready: 1'b0, err: 1'b0});
      sb.push_back('{ctl: {ds, 8'd0}, val: 64'd0, busy: 1'b1, ready: 1'b0, err: 1'b0});
    end
    sb.push_back('{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b1, err: 1'b0});
  endfunction

  task automatic drive_req(input logic [7:0] ds, input logic [63:0] y, input logic [63:0] r,
                           input logic [63:0] ri, input logic [63:0] ro, input logic act);
    req_valid = 1'b1; req_dataset = ds; req_yset = y; req_rset = r;
    req_riset = ri; req_roset = ro; req_activate = act;
  endtask

  task automatic scramble_inputs();
    req_dataset = 8'($urandom_range(0, 1)); req_yset = rnd64(); req_rset = rnd64();
    req_riset = rnd64(); req_roset = rnd64(); req_activate = 1'($urandom);
  endtask

  task automatic test_reset();
    exp_t o;
    exp_t e;
    nReset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      o = observed();
      e = '{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b0, err: 1'b0};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_state: got %h required %h", o, e);
      end
    end
    nReset = 1'b1;
    @(negedge clk);
    o = observed();
    e = '{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b1, err: 1'b0};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", o, e);
    end
  endtask

  // One sequence; inputs are scrambled right after the handshake.
  task automatic test_sequence(input string name, input logic [7:0] ds, input logic [63:0] y,
                               input logic act);
    logic [63:0] r, ri, ro;
    exp_t o;
    exp_t e;
    int nbusy;
    r = rnd64(); ri = rnd64(); ro = rnd64();
    nbusy = 0;
    drive_req(ds, y, r, ri, ro, act);
    push_seq(ds, y, r, ri, ro, act);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observed();
      if (busy === 1'b1) nbusy++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", name, o, e);
      end
    end
    n_checks++;
    if (nbusy != (act ? 6 : 5) * int'(Hold + 1)) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d required %0d", name, nbusy,
               (act ? 6 : 5) * int'(Hold + 1));
    end
  endtask

  task automatic test_invalid_dataset();
    exp_t o;
    exp_t e;
    drive_req(8'd5, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_errs++;
    @(negedge clk);
    o = observed();
    e = '{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b1, err: 1'b1};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL invalid_pulse: got %h required %h", o, e);
    end
    @(negedge clk);
    o = observed();
    e.err = 1'b0;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL invalid_after: got %h required %h", o, e);
    end
`ifdef RRG_SEQ_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'(exp_errs)) begin
      n_fail++;
      $display("FAIL err_count: got %0d required %0d", err_count, exp_errs);
    end
`endif
  endtask

  task automatic test_reset_midseq();
    exp_t o;
    exp_t e;
    drive_req(8'd1, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // First WRITE_ROSET cycle is cycle 3*(Hold+1)+1 after the handshake.
    repeat (3 * (Hold + 1) + 1) @(negedge clk);
    n_checks++;
    if (reg_control !== 16'h0104) begin
      n_fail++;
      $display("FAIL midseq_in_wr_ro: got %h required %h", reg_control, 16'h0104);
    end
    nReset = 1'b0;
    @(negedge clk);
    o = observed();
    e = '{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b0, err: 1'b0};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL midseq_reset: got %h required %h", o, e);
    end
    nReset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      o = observed();
      e = '{ctl: 16'd0, val: 64'd0, busy: 1'b0, ready: 1'b1, err: 1'b0};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midseq_quiet cycle %0d: got %h required %h", i, o, e);
      end
    end
    exp_errs = 0;
  endtask

  // Three requests with req_valid held; the next request's fields appear mid-sequence.
  task automatic test_back_to_back();
    logic [7:0]  ds[3];
    logic [63:0] y[3], r[3], ri[3], ro[3];
    logic        act[3];
    int          start[3];
    int          idx;
    exp_t        o;
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      ds[k] = 8'(k % 2); y[k] = rnd64(); r[k] = rnd64(); ri[k] = rnd64(); ro[k] = rnd64();
      act[k] = (k == 1);
      start[k] = sb.size();
      push_seq(ds[k], y[k], r[k], ri[k], ro[k], act[k]);
    end
    drive_req(ds[0], y[0], r[0], ri[0], ro[0], act[0]);
    idx = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back idx %0d: got %h required %h", idx, o, e);
      end
      if (idx == 4) drive_req(ds[1], y[1], r[1], ri[1], ro[1], act[1]);
      if (idx == start[1] + 4) drive_req(ds[2], y[2], r[2], ri[2], ro[2], act[2]);
      if (idx == start[2] + 4) begin
        req_valid = 1'b0;
        scramble_inputs();
      end
      idx++;
    end
  endtask

`ifdef RRG_SEQ_ERRCNT_EN
  task automatic test_err_saturate();
    drive_req(8'd200, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    repeat (300) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d required 255", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence("seq_no_activate", 8'd1, 64'h0000_1234_5678_9ABC, 1'b0);
    test_sequence("seq_activate", 8'd1, 64'h0000_1234_5678_9ABC, 1'b1);
    test_sequence("seq_ds0", 8'd0, rnd64(), 1'b0);
    test_invalid_dataset();
    test_reset_midseq();
    test_back_to_back();
    test_sequence("seq_after_b2b", 8'd1, rnd64(), 1'b1);
`ifdef RRG_SEQ_ERRCNT_EN
    test_err_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
